// File: rtl/lutfifo32_rd.sv
// 32-entry single-clock FIFO on distributed RAM with async read.
// Owns pointers, occupancy, status flags and sticky error flags.
module lutfifo32_rd #(
  parameter int WIDTH        = 64,
  parameter int AFULL_THRESH = 28
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] WrData,
  input  logic             WrEn,
  output logic             Full,
  output logic             AlmostFull,
  output logic [WIDTH-1:0] RdData,
  input  logic             RdEn,
  output logic             Empty,
  output logic [5:0]       Count,
  output logic             Overflow,
  output logic             Underflow,
  input  logic             ClrErr
);

  logic [WIDTH-1:0] mem [32];
  logic [4:0]       wa;
  logic [4:0]       ra;
  logic             push;
  logic             pop;
  logic             ovf_ev;
  logic             unf_ev;
  logic [5:0]       cnt_nxt;

  // a pop frees the head slot, so a full FIFO may accept a push alongside it
  assign push   = WrEn & (~Full | RdEn);
  assign pop    = RdEn & ~Empty;
  assign ovf_ev = WrEn & Full & ~RdEn;
  assign unf_ev = RdEn & Empty;

  always_comb begin
    cnt_nxt = Count;
    unique case (1'b1)
      push & ~pop: cnt_nxt = Count + 6'd1;
      pop & ~push: cnt_nxt = Count - 6'd1;
      default:     cnt_nxt = Count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wa] <= WrData;
  end

  assign RdData = mem[ra];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wa         <= 5'd0;
      ra         <= 5'd0;
      Count      <= 6'd0;
      Empty      <= 1'b1;
      Full       <= 1'b0;
      AlmostFull <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      if (push) wa <= wa + 5'd1;
      if (pop)  ra <= ra + 5'd1;
      Count      <= cnt_nxt;
      Empty      <= (cnt_nxt == 6'd0);
      Full       <= (cnt_nxt == 6'd32);
      AlmostFull <= (cnt_nxt >= 6'(AFULL_THRESH));
      // a new error in the same cycle as a clear keeps the flag set
      Overflow   <= ovf_ev | (Overflow & ~ClrErr);
      Underflow  <= unf_ev | (Underflow & ~ClrErr);
    end
  end

  a_count: assert property (@(posedge CLK) disable iff (Reset)
    (Count <= 6'd32) && (Count[4:0] == 5'(wa - ra)));

  a_fe: assert property (@(posedge CLK) disable iff (Reset)
    !(Full && Empty));

endmodule

// File: tb/tb_lutfifo32_rd.sv
// Randomized self-checking bench for lutfifo32_rd.
// A queue-based model tracks contents, occupancy and sticky errors.
module tb_lutfifo32_rd;

  logic        CLK;
  logic        Reset;
  logic [63:0] WrData;
  logic        WrEn;
  logic        Full;
  logic        AlmostFull;
  logic [63:0] RdData;
  logic        RdEn;
  logic        Empty;
  logic [5:0]  Count;
  logic        Overflow;
  logic        Underflow;
  logic        ClrErr;

  int total;
  int bad;

  logic [63:0] q[$];
  logic        m_ovf;
  logic        m_unf;

  lutfifo32_rd dut (
    .CLK(CLK), .Reset(Reset), .WrData(WrData), .WrEn(WrEn),
    .Full(Full), .AlmostFull(AlmostFull), .RdData(RdData),
    .RdEn(RdEn), .Empty(Empty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow), .ClrErr(ClrErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_step(input logic we, input logic re,
                                     input logic [63:0] wd,
                                     input logic clr);
    int  n;
    logic ov;
    logic un;
    n  = q.size();
    ov = we && (n == 32) && !re;
    un = re && (n == 0);
    if (re && n > 0) void'(q.pop_front());
    if (we && (n < 32 || re)) q.push_back(wd);
    m_ovf = ov | (m_ovf & !clr);
    m_unf = un | (m_unf & !clr);
  endfunction

  task automatic tick(input logic we, input logic re,
                      input logic [63:0] wd, input logic clr);
    WrEn = we; RdEn = re; WrData = wd; ClrErr = clr;
    @(posedge CLK);
    model_step(we, re, wd, clr);
    #1;
    WrEn = 1'b0; RdEn = 1'b0; ClrErr = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (Count !== 6'd0 || Empty !== 1'b1 || Full !== 1'b0 ||
        AlmostFull !== 1'b0 || Overflow !== 1'b0 || Underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset: cnt=%0d e=%b f=%b af=%b ov=%b un=%b want 0 1 0 0 0 0",
               Count, Empty, Full, AlmostFull, Overflow, Underflow);
    end
  endtask

  task automatic test_push3();
    tick(1, 0, 64'h11, 0);
    tick(1, 0, 64'h12, 0);
    tick(1, 0, 64'h13, 0);
    total++;
    if (Count !== 6'd3 || RdData !== 64'h11 || Empty !== 1'b0 || Full !== 1'b0) begin
      bad++;
      $display("FAIL push3: cnt=%0d rd=%h e=%b f=%b want 3 11 0 0",
               Count, RdData, Empty, Full);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick(1, 0, 64'(k - 1), 0);
      total++;
      if (Count !== 6'(k) || AlmostFull !== (k >= 28) || Full !== (k == 32) ||
          Empty !== 1'b0) begin
        bad++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b f=%b e=%b", k, Count,
                 AlmostFull, Full, Empty);
      end
    end
    tick(1, 0, 64'hDEAD, 0);
    total++;
    if (Overflow !== 1'b1 || Count !== 6'd32 || Full !== 1'b1 ||
        RdData !== 64'h0) begin
      bad++;
      $display("FAIL overflow: ov=%b cnt=%0d f=%b rd=%h want 1 32 1 0",
               Overflow, Count, Full, RdData);
    end
  endtask

  task automatic test_full_pushpop();
    logic [63:0] exp;
    total++;
    if (RdData !== 64'h0) begin
      bad++;
      $display("FAIL fullpp_head: got %h want 0", RdData);
    end
    tick(1, 1, 64'hAA, 0);
    total++;
    if (Count !== 6'd32 || Full !== 1'b1 || RdData !== 64'h1) begin
      bad++;
      $display("FAIL fullpp: cnt=%0d f=%b rd=%h want 32 1 1", Count, Full, RdData);
    end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 31) ? 64'(i + 1) : 64'hAA;
      total++;
      if (RdData !== exp) begin
        bad++;
        $display("FAIL drain[%0d]: got %h want %h", i, RdData, exp);
      end
      tick(0, 1, 64'h0, 0);
    end
    total++;
    if (Empty !== 1'b1 || Count !== 6'd0 || Full !== 1'b0) begin
      bad++;
      $display("FAIL drained: e=%b cnt=%0d f=%b want 1 0 0", Empty, Count, Full);
    end
  endtask

  task automatic test_underflow();
    tick(0, 1, 64'h0, 0);
    total++;
    if (Underflow !== 1'b1 || Count !== 6'd0 || Empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow: un=%b cnt=%0d e=%b want 1 0 1", Underflow, Count, Empty);
    end
    tick(1, 1, 64'h55, 0);
    total++;
    if (Count !== 6'd1 || RdData !== 64'h55 || Underflow !== 1'b1) begin
      bad++;
      $display("FAIL pushpop_empty: cnt=%0d rd=%h un=%b want 1 55 1",
               Count, RdData, Underflow);
    end
    tick(0, 0, 64'h0, 1);
    total++;
    if (Overflow !== 1'b0 || Underflow !== 1'b0 || Count !== 6'd1) begin
      bad++;
      $display("FAIL clrerr: ov=%b un=%b cnt=%0d want 0 0 1", Overflow, Underflow, Count);
    end
    tick(0, 0, 64'h0, 0);
    tick(0, 1, 64'h0, 0);
    tick(0, 1, 64'h0, 1);
    total++;
    if (Underflow !== 1'b1) begin
      bad++;
      $display("FAIL set_wins: un=%b want 1", Underflow);
    end
  endtask

  task automatic test_stream();
    logic [63:0] d;
    do_reset();
    tick(1, 0, {$urandom, $urandom}, 0);
    for (int i = 0; i < 100; i++) begin
      total++;
      if (RdData !== q[0]) begin
        bad++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, RdData, q[0]);
      end
      d = {$urandom, $urandom};
      tick(1, 1, d, 0);
      total++;
      if (Count !== 6'd1 || RdData !== d) begin
        bad++;
        $display("FAIL stream_cnt[%0d]: cnt=%0d rd=%h want 1 %h", i, Count, RdData, d);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 0, 64'(i + 100), 0);
    #3;
    Reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    total++;
    if (Empty !== 1'b1 || Count !== 6'd0) begin
      bad++;
      $display("FAIL async_reset: e=%b cnt=%0d want 1 0", Empty, Count);
    end
    #2;
    Reset = 1'b0;
    tick(1, 0, 64'h77, 0);
    total++;
    if (RdData !== 64'h77 || Count !== 6'd1) begin
      bad++;
      $display("FAIL after_reset: rd=%h cnt=%0d want 77 1", RdData, Count);
    end
  endtask

  task automatic test_random();
    logic we;
    logic re;
    logic clr;
    int   n;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ((i / 150) % 2 == 0) begin
        we = ($urandom_range(0, 99) < 80);
        re = ($urandom_range(0, 99) < 30);
      end else begin
        we = ($urandom_range(0, 99) < 30);
        re = ($urandom_range(0, 99) < 80);
      end
      clr = ($urandom_range(0, 99) < 5);
      tick(we, re, {$urandom, $urandom}, clr);
      n = q.size();
      total++;
      if (Count !== 6'(n) || Empty !== (n == 0) || Full !== (n == 32) ||
          AlmostFull !== (n >= 28) || Overflow !== m_ovf ||
          Underflow !== m_unf || (n > 0 && RdData !== q[0])) begin
        bad++;
        $display("FAIL rand[%0d]: cnt=%0d/%0d e=%b f=%b af=%b ov=%b/%b un=%b/%b rd=%h",
                 i, Count, n, Empty, Full, AlmostFull, Overflow, m_ovf,
                 Underflow, m_unf, RdData);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    Reset  = 1'b1;
    WrEn   = 1'b0;
    RdEn   = 1'b0;
    ClrErr = 1'b0;
    WrData = 64'h0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    test_reset();
    test_push3();
    test_fill();
    test_full_pushpop();
    test_underflow();
    test_stream();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
